// File: rtl/rhd_cmd_pkg.sv
// Shared command encodings, state enums and the result-tag type for the RHD
// command sequencer and its result tagger.
package rhd_cmd_pkg;

  localparam logic [1:0]  CMD_WRITE       = 2'b10;
  localparam logic [1:0]  CMD_READ        = 2'b11;
  localparam logic [1:0]  CMD_CONVERT     = 2'b00;
  localparam logic [15:0] CALIBRATE_WORD  = 16'h5500;
  localparam logic [15:0] DUMMY_READ_WORD = {CMD_READ, 6'd40, 8'h00};

  typedef enum logic [2:0] {
    PH_IDLE, PH_INIT, PH_CAL, PH_DUMMY, PH_SCAN
  } phase_t;

  typedef enum logic [1:0] {
    XS_ISSUE, XS_WAIT_DONE, XS_WAIT_LOW
  } xact_t;

  typedef struct packed {
    logic       valid;
    logic       is_convert;
    logic [5:0] chan;
  } tag_t;

  function automatic logic [15:0] convert_word(input logic [5:0] c, input logic h);
    return {CMD_CONVERT, c, 7'b0, h};
  endfunction

endpackage

// File: rtl/rhd_result_tagger.sv
// Two-deep tag pipeline: the result of transaction n belongs to the command
// issued two transactions earlier, so tags ride along until their data lands.
module rhd_result_tagger
  import rhd_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        push,
  input  tag_t        push_tag,
  input  logic [15:0] a_data,
  input  logic [15:0] b_data,
  output logic        sample_valid,
  output logic [5:0]  sample_chan,
  output logic [15:0] sample_a,
  output logic [15:0] sample_b,
  output logic        frame_start
);

  tag_t tag_n1, tag_n2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_n1       <= '0;
      tag_n2       <= '0;
      sample_valid <= 1'b0;
      sample_chan  <= '0;
      sample_a     <= '0;
      sample_b     <= '0;
      frame_start  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_start  <= 1'b0;
      if (clear) begin
        tag_n1 <= '0;
        tag_n2 <= '0;
      end else if (push) begin
        tag_n1      <= push_tag;
        tag_n2      <= tag_n1;
        sample_a    <= a_data;
        sample_b    <= b_data;
        sample_chan <= tag_n2.chan;
        // Only CONVERT results carry samples; writes/reads/calibrate are dropped.
        if (tag_n2.valid && tag_n2.is_convert) begin
          sample_valid <= 1'b1;
          frame_start  <= (tag_n2.chan == 6'd0);
        end
      end
    end
  end

endmodule

// File: rtl/rhd_cmd_sequencer.sv
// RHD command scheduler: one-time init (register writes, calibrate, dummy
// reads) followed by continuous CONVERT scanning, paced by SPI start/done.
module rhd_cmd_sequencer
  import rhd_cmd_pkg::*;
#(
  parameter int   NUM_CHANNELS  = 32,
  parameter int   NUM_INIT_REGS = 18,
  parameter int   NUM_CAL_DUMMY = 9,
  parameter logic CONVERT_H     = 1'b0
)(
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  output logic [5:0]  cfg_index,
  input  logic [13:0] cfg_word,
  output logic        spi_start,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_a_data,
  input  logic [15:0] spi_b_data,
  output logic        sample_valid,
  output logic [5:0]  sample_chan,
  output logic [15:0] sample_a,
  output logic [15:0] sample_b,
  output logic        frame_start,
  output logic        init_done,
  output logic        busy
);

  localparam logic [5:0] LAST_CHAN  = 6'(NUM_CHANNELS - 1);
  localparam logic [5:0] LAST_REG   = 6'(NUM_INIT_REGS - 1);
  localparam logic [7:0] LAST_DUMMY = 8'(NUM_CAL_DUMMY - 1);

  phase_t     phase;
  xact_t      xs;
  logic       done_q, last_wr;
  logic [5:0] chan_cnt, next_chan;
  logic [7:0] dummy_cnt;
  logic       done_rise, xact_end, push, scan_entry;
  tag_t       cur_tag;

  assign done_rise  = spi_done && !done_q;
  assign xact_end   = (phase != PH_IDLE) && (xs == XS_WAIT_LOW) && !spi_done;
  assign push       = (phase != PH_IDLE) && (xs == XS_WAIT_DONE) && done_rise;
  assign next_chan  = (chan_cnt == LAST_CHAN) ? 6'd0 : chan_cnt + 6'd1;
  assign scan_entry = enable &&
                      ((phase == PH_IDLE && init_done && !spi_done) ||
                       (phase == PH_DUMMY && xact_end && dummy_cnt == LAST_DUMMY));
  assign cur_tag    = '{valid: 1'b1, is_convert: (phase == PH_SCAN), chan: chan_cnt};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase     <= PH_IDLE;
      xs        <= XS_ISSUE;
      done_q    <= 1'b0;
      last_wr   <= 1'b0;
      chan_cnt  <= '0;
      dummy_cnt <= '0;
      cfg_index <= '0;
      spi_start <= 1'b0;
      spi_cmd   <= '0;
      init_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done_q    <= spi_done;
      spi_start <= 1'b0;
      if (phase == PH_IDLE) begin
        // Never start while a previous (possibly abandoned) window is still open.
        if (enable && !spi_done) begin
          busy      <= 1'b1;
          xs        <= XS_ISSUE;
          spi_start <= 1'b1;
          if (init_done) begin
            phase    <= PH_SCAN;
            chan_cnt <= '0;
            spi_cmd  <= convert_word(6'd0, CONVERT_H);
          end else begin
            phase   <= PH_INIT;
            last_wr <= 1'b0;
            spi_cmd <= {CMD_WRITE, cfg_word};
          end
        end
      end else begin
        case (xs)
          XS_ISSUE: xs <= XS_WAIT_DONE;
          XS_WAIT_DONE: begin
            if (done_rise) begin
              xs <= XS_WAIT_LOW;
              // Advance the table index early so cfg_word settles before reissue.
              if (phase == PH_INIT) begin
                if (cfg_index == LAST_REG) last_wr <= 1'b1;
                else cfg_index <= cfg_index + 6'd1;
              end
            end
          end
          XS_WAIT_LOW: begin
            if (!spi_done) begin
              xs        <= XS_ISSUE;
              spi_start <= 1'b1;
              case (phase)
                PH_INIT: begin
                  if (last_wr) begin
                    phase   <= PH_CAL;
                    spi_cmd <= CALIBRATE_WORD;
                  end else begin
                    spi_cmd <= {CMD_WRITE, cfg_word};
                  end
                end
                PH_CAL: begin
                  phase     <= PH_DUMMY;
                  dummy_cnt <= '0;
                  spi_cmd   <= DUMMY_READ_WORD;
                end
                PH_DUMMY: begin
                  if (dummy_cnt == LAST_DUMMY) begin
                    init_done <= 1'b1;
                    if (enable) begin
                      phase    <= PH_SCAN;
                      chan_cnt <= '0;
                      spi_cmd  <= convert_word(6'd0, CONVERT_H);
                    end else begin
                      phase     <= PH_IDLE;
                      busy      <= 1'b0;
                      spi_start <= 1'b0;
                    end
                  end else begin
                    dummy_cnt <= dummy_cnt + 8'd1;
                    spi_cmd   <= DUMMY_READ_WORD;
                  end
                end
                PH_SCAN: begin
                  if (enable) begin
                    chan_cnt <= next_chan;
                    spi_cmd  <= convert_word(next_chan, CONVERT_H);
                  end else begin
                    phase     <= PH_IDLE;
                    busy      <= 1'b0;
                    spi_start <= 1'b0;
                  end
                end
                default: begin
                  phase     <= PH_IDLE;
                  busy      <= 1'b0;
                  spi_start <= 1'b0;
                end
              endcase
            end
          end
          default: xs <= XS_ISSUE;
        endcase
      end
    end
  end

  rhd_result_tagger u_tagger (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (scan_entry),
    .push         (push),
    .push_tag     (cur_tag),
    .a_data       (spi_a_data),
    .b_data       (spi_b_data),
    .sample_valid (sample_valid),
    .sample_chan  (sample_chan),
    .sample_a     (sample_a),
    .sample_b     (sample_b),
    .frame_start  (frame_start)
  );

endmodule
